// File: rtl/divider_seq.sv
// divider_seq: sequential restoring divider, radix-2, one quotient bit per clock.
// Unsigned division with a run-time divisor, start/busy/done handshake and
// divide-by-zero detection.
//
// Parameters:
//   WIDTH      dividend and quotient width (>= 2)
//   DIV_WIDTH  divisor and remainder width (>= 1, <= WIDTH)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        request; accepted on a rising edge only while idle
//   dividend     unsigned dividend, captured with an accepted start
//   divisor      unsigned divisor, captured with an accepted start
//   quotient     registered quotient, updated on the done edge
//   remainder    registered remainder, updated on the done edge
//   done         one-cycle pulse when the results update
//   busy         high while a division is in progress
//   div_by_zero  set with done when the captured divisor was zero
module divider_seq #(
  parameter int WIDTH     = 14,
  parameter int DIV_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 done,
  output logic                 busy,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;

  state_t               state, state_n;

  // Dividend shift register; quotient bits enter at the LSB as dividend
  // bits leave at the MSB, so it holds the full quotient after WIDTH steps.
  logic [WIDTH-1:0]     sr, sr_n;
  logic [DIV_WIDTH-1:0] dvs, dvs_n;
  // Partial remainder. After every step it is strictly below the divisor,
  // so the top bit of the (DIV_WIDTH+1)-bit working value is always zero
  // here and only DIV_WIDTH bits are stored.
  logic [DIV_WIDTH-1:0] prem, prem_n;
  logic [CW-1:0]        cnt, cnt_n;

  logic [WIDTH-1:0]     quotient_n;
  logic [DIV_WIDTH-1:0] remainder_n;
  logic                 done_n, busy_n, dbz_n;

  // One restoring step.
  logic [DIV_WIDTH:0]   shifted;
  logic                 fits;
  logic [DIV_WIDTH-1:0] trial;
  logic [DIV_WIDTH-1:0] step_rem;
  logic [WIDTH-1:0]     step_sr;

  always_comb begin
    shifted  = {prem, sr[WIDTH-1]};
    fits     = (shifted >= {1'b0, dvs});
    // When the subtraction fits the true difference is below the divisor,
    // so the modulo-2^DIV_WIDTH difference of the low bits is exact.
    trial    = shifted[DIV_WIDTH-1:0] - dvs;
    step_rem = fits ? trial : shifted[DIV_WIDTH-1:0];
    step_sr  = {sr[WIDTH-2:0], fits};
  end

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    dvs_n       = dvs;
    prem_n      = prem;
    cnt_n       = cnt;
    quotient_n  = quotient;
    remainder_n = remainder;
    done_n      = 1'b0;
    busy_n      = busy;
    dbz_n       = div_by_zero;

    case (state)
      IDLE: begin
        if (start) begin
          sr_n   = dividend;
          dvs_n  = divisor;
          prem_n = '0;
          cnt_n  = CW'(WIDTH - 1);
          busy_n = 1'b1;
          if (divisor != '0) begin
            state_n = RUN;
            dbz_n   = 1'b0;
          end else begin
            state_n = ZERO;
          end
        end
      end

      RUN: begin
        prem_n = step_rem;
        sr_n   = step_sr;
        cnt_n  = cnt - 1'b1;
        if (cnt == '0) begin
          quotient_n  = step_sr;
          remainder_n = step_rem;
          done_n      = 1'b1;
          busy_n      = 1'b0;
          state_n     = IDLE;
        end
      end

      ZERO: begin
        quotient_n  = '1;
        remainder_n = sr[DIV_WIDTH-1:0];
        dbz_n       = 1'b1;
        done_n      = 1'b1;
        busy_n      = 1'b0;
        state_n     = IDLE;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      dvs         <= dvs_n;
      prem        <= prem_n;
      cnt         <= cnt_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      done        <= done_n;
      busy        <= busy_n;
      div_by_zero <= dbz_n;
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        t_start;
  logic        sel;          // 0: 14/4 instance, 1: 8/8 instance
  logic [13:0] t_dvd;
  logic [7:0]  t_dvs;

  logic [13:0] q14;
  logic [3:0]  r14;
  logic        done14, busy14, dbz14;
  logic [7:0]  q8;
  logic [7:0]  r8;
  logic        done8, busy8, dbz8;

  logic [31:0] cur_q, cur_r;
  logic        cur_done, cur_busy, cur_dbz;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  divider_seq #(.WIDTH(14), .DIV_WIDTH(4)) u14 (
    .clk(clk), .reset(reset), .start(t_start & ~sel),
    .dividend(t_dvd), .divisor(t_dvs[3:0]),
    .quotient(q14), .remainder(r14), .done(done14), .busy(busy14),
    .div_by_zero(dbz14)
  );

  divider_seq #(.WIDTH(8), .DIV_WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(t_start & sel),
    .dividend(t_dvd[7:0]), .divisor(t_dvs),
    .quotient(q8), .remainder(r8), .done(done8), .busy(busy8),
    .div_by_zero(dbz8)
  );

  assign cur_q    = sel ? {24'b0, q8} : {18'b0, q14};
  assign cur_r    = sel ? {24'b0, r8} : {28'b0, r14};
  assign cur_done = sel ? done8 : done14;
  assign cur_busy = sel ? busy8 : busy14;
  assign cur_dbz  = sel ? dbz8  : dbz14;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  // One division on the selected instance. Expected results come from the
  // table when use_exp is set, otherwise from plain integer arithmetic.
  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input bit use_exp, input logic [31:0] eq, input logic [31:0] er,
                    input bit ez, input bit inject);
    int          w, dw, lat;
    logic [31:0] mq, mr, pq, pr;
    bit          mz, seen, stable;
    w  = sel ? 8 : 14;
    dw = sel ? 8 : 4;
    if (use_exp) begin
      mq = eq; mr = er; mz = ez;
    end else if (b == 0) begin
      mq = (32'd1 << w) - 1;
      mr = a & ((32'd1 << dw) - 1);
      mz = 1'b1;
    end else begin
      mq = a / b;
      mr = a % b;
      mz = 1'b0;
    end
    pq = cur_q;
    pr = cur_r;
    t_start = 1'b1;
    t_dvd   = a[13:0];
    t_dvs   = b[7:0];
    @(posedge clk); #1;
    t_start = 1'b0;
    t_dvd   = 14'($urandom);
    t_dvs   = 8'($urandom);
    chk("busy_after_start", 32'(cur_busy), 32'd1);
    chk("done_after_start", 32'(cur_done), 32'd0);
    if (b != 0) chk("dbz_cleared_on_start", 32'(cur_dbz), 32'd0);
    lat = 0; seen = 1'b0; stable = 1'b1;
    while (!seen && lat < 64) begin
      if (inject && lat == 2) begin
        t_start = 1'b1; t_dvd = 14'd100; t_dvs = 8'd7;
      end
      @(posedge clk); #1;
      lat++;
      t_start = 1'b0;
      if (cur_done) seen = 1'b1;
      else if (cur_q !== pq || cur_r !== pr || cur_busy !== 1'b1) stable = 1'b0;
    end
    chk("latency", 32'(lat), (b == 0) ? 32'd1 : 32'(w));
    chk("outputs_stable_while_busy", 32'(stable), 32'd1);
    chk("quotient", cur_q, mq);
    chk("remainder", cur_r, mr);
    chk("div_by_zero", 32'(cur_dbz), 32'(mz));
    chk("busy_at_done", 32'(cur_busy), 32'd0);
    if (b != 0) begin
      chk("invariant", cur_q * b + cur_r, a);
      chk("rem_lt_divisor", 32'(cur_r < b), 32'd1);
    end
  endtask

  task automatic idle_no_done(input int n);
    int extra;
    extra = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (cur_done || cur_busy) extra++;
    end
    chk("no_spurious_done_or_busy", 32'(extra), 32'd0);
  endtask

  typedef struct {
    bit          s;
    logic [31:0] a, b, q, r;
    bit          z;
    bit          inj;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; t_start = 1'b0; sel = 1'b0; t_dvd = '0; t_dvs = '0;

    tbl.push_back('{0, 9999,  10, 999,   9, 0, 0});
    tbl.push_back('{0, 5,     10, 0,     5, 0, 0});
    tbl.push_back('{0, 16383, 1,  16383, 0, 0, 0});
    tbl.push_back('{0, 1234,  0,  16383, 2, 1, 0});
    tbl.push_back('{0, 100,   7,  14,    2, 0, 0});
    tbl.push_back('{0, 9999,  10, 999,   9, 0, 1});
    tbl.push_back('{0, 100,   7,  14,    2, 0, 0});
    tbl.push_back('{0, 16383, 15, 1092,  3, 0, 0});
    tbl.push_back('{0, 0,     3,  0,     0, 0, 0});
    tbl.push_back('{0, 15,    15, 1,     0, 0, 0});
    tbl.push_back('{1, 255,   1,  255,   0, 0, 0});
    tbl.push_back('{1, 200,   201, 0,    200, 0, 0});
    tbl.push_back('{1, 77,    0,  255,   77, 1, 0});
    tbl.push_back('{1, 250,   7,  35,    5, 0, 0});

    #12;
    chk("reset_q14",    32'(q14), 32'd0);
    chk("reset_r14",    32'(r14), 32'd0);
    chk("reset_flags14", {29'b0, done14, busy14, dbz14}, 32'd0);
    chk("reset_q8",     32'(q8), 32'd0);
    chk("reset_r8",     32'(r8), 32'd0);
    chk("reset_flags8", {29'b0, done8, busy8, dbz8}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (sel !== tbl[i].s) begin
        sel = tbl[i].s;
        #1;
      end
      op(tbl[i].a, tbl[i].b, 1'b1, tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].inj);
    end
    idle_no_done(4);

    // Reset in the middle of a 9999/10 division.
    sel = 1'b0; #1;
    t_start = 1'b1; t_dvd = 14'd9999; t_dvs = 8'd10;
    @(posedge clk); #1;
    t_start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", 32'(busy14), 32'd0);
    chk("async_reset_done", 32'(done14), 32'd0);
    chk("async_reset_q",    32'(q14), 32'd0);
    chk("async_reset_r",    32'(r14), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    idle_no_done(18);
    op(9999, 10, 1'b0, 0, 0, 1'b0, 1'b0);

    // Random sweeps, back-to-back, on both configurations.
    for (int i = 0; i < 2000; i++)
      op(32'($urandom_range(0, 16383)), 32'($urandom_range(1, 15)), 1'b0, 0, 0, 1'b0, 1'b0);
    sel = 1'b1; #1;
    for (int i = 0; i < 2000; i++)
      op(32'($urandom_range(0, 255)), 32'($urandom_range(1, 255)), 1'b0, 0, 0, 1'b0, 1'b0);
    idle_no_done(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
